// File: rtl/lut_pkg.sv
// Shared types and defaults for the lookup-table access controller.
package lut_pkg;

  localparam int LUT_ASIZE  = 8;
  localparam int LUT_DWIDTH = 8;
  localparam int LUT_CNT_W  = 16;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    IDLE = 2'b01
  } lut_state_e;

  typedef struct packed {
    logic                  wr;
    logic [LUT_ASIZE-1:0]  addr;
    logic [LUT_DWIDTH-1:0] wdata;
  } lut_req_t;

  // Saturating increment used by the optional activity counters.
  function automatic logic [LUT_CNT_W-1:0] lut_sat_inc(input logic [LUT_CNT_W-1:0] v);
    return (v == {LUT_CNT_W{1'b1}}) ? v : v + {{(LUT_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/lut_mem.sv
// Table storage: one synchronous write port, one combinational read port.
module lut_mem
  import lut_pkg::*;
#(
  parameter int ASIZE  = LUT_ASIZE,
  parameter int DWIDTH = LUT_DWIDTH
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ASIZE-1:0]  i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [ASIZE-1:0]  i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  localparam int ARANGE = 1 << ASIZE;

  logic [DWIDTH-1:0] r_mem [ARANGE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lut_access_ctrl.sv
// Lookup-table access controller: init sweep, then one read/write command per cycle.
// Optional read/write activity counters are built when LUT_ACCESS_CNT_EN is defined.
module lut_access_ctrl
  import lut_pkg::*;
#(
  parameter int                ASIZE    = LUT_ASIZE,
  parameter int                ARANGE   = 1 << ASIZE,
  parameter int                DWIDTH   = LUT_DWIDTH,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ASIZE-1:0]  req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              init_done,
`ifdef LUT_ACCESS_CNT_EN
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
`endif
  output lut_state_e        o_dbg_state
);

  // Handshake: a command transfers on a rising edge with req_valid && req_ready;
  // a response transfers with rsp_valid && rsp_ready. Both may transfer in one cycle.

  localparam logic [ASIZE:0] PTR_LAST = (ASIZE+1)'(ARANGE - 1);
  localparam logic [ASIZE:0] PTR_ONE  = (ASIZE+1)'(1);

  lut_state_e        r_state;
  logic [ASIZE:0]    r_ptr;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic              r_rsp_wr;
  logic [DWIDTH-1:0] r_rsp_data;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_mem_we;
  logic [ASIZE-1:0]  w_mem_waddr;
  logic [DWIDTH-1:0] w_mem_wdata;
  logic [DWIDTH-1:0] w_rd_data;

  assign w_req_ready = (r_state == IDLE) && r_init_done && (!r_rsp_valid || rsp_ready) && !clr;
  assign w_accept    = req_valid && w_req_ready;

  // Sweep writes own the port during INIT; otherwise only accepted writes reach it.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = req_addr;
    w_mem_wdata = req_wdata;
    if (!rst && !clr) begin
      if (r_state == INIT) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_ptr[ASIZE-1:0];
        w_mem_wdata = INIT_VAL;
      end else if (r_state == IDLE) begin
        w_mem_we = w_accept && req_wr;
      end
    end
  end

  lut_mem #(
    .ASIZE  (ASIZE),
    .DWIDTH (DWIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (req_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_wr    <= 1'b0;
      r_rsp_data  <= '0;
    end else if (clr) begin
      // Pending response is dropped; rsp_wr/rsp_data keep their last value.
      r_state     <= INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_ptr <= r_ptr + PTR_ONE;
          if (r_ptr == PTR_LAST) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= req_wr;
            r_rsp_data  <= req_wr ? req_wdata : w_rd_data;
          end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= INIT;
          r_ptr       <= '0;
          r_init_done <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LUT_ACCESS_CNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  // w_accept is only ever high in IDLE, so the sweep never counts.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_accept) begin
      if (req_wr) begin
        r_wr_cnt <= lut_sat_inc(r_wr_cnt);
      end else begin
        r_rd_cnt <= lut_sat_inc(r_rd_cnt);
      end
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_wr      = r_rsp_wr;
  assign rsp_data    = r_rsp_data;
  assign init_done   = r_init_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lut_access_ctrl.sv
// Directed bench for lut_access_ctrl: init sweep, read/write, backpressure, clr and rst.
module tb_lut_access_ctrl;
  import lut_pkg::*;

  localparam int         ASIZE    = 8;
  localparam int         DWIDTH   = 8;
  localparam logic [7:0] INIT_VAL = 8'h5A;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [ASIZE-1:0] req_addr;
  logic [7:0]       req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_wr;
  logic [7:0]       rsp_data;
  logic             init_done;
  lut_state_e       dbg_state;
`ifdef LUT_ACCESS_CNT_EN
  logic [15:0]      rd_cnt;
  logic [15:0]      wr_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  lut_access_ctrl #(
    .ASIZE    (ASIZE),
    .ARANGE   (1 << ASIZE),
    .DWIDTH   (DWIDTH),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_wr      (rsp_wr),
    .rsp_data    (rsp_data),
    .init_done   (init_done),
`ifdef LUT_ACCESS_CNT_EN
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until init_done rises; note whether req_ready ever rose during INIT.
  task automatic wait_init(output int cnt, output bit early);
    cnt   = 0;
    early = 1'b0;
    while (!init_done && cnt < 1000) begin
      if (req_ready) early = 1'b1;
      tick();
      cnt++;
    end
  endtask

  task automatic drive_req(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int cnt;
    bit early;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_wr !== 1'b0 || rsp_data !== 8'h00 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b wr=%b data=%h done=%b, want 0 0 0 00 0",
               req_ready, rsp_valid, rsp_wr, rsp_data, init_done);
    end
    n_cmp++;
    if (dbg_state !== INIT) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, INIT);
    end
    wait_init(cnt, early);
    n_cmp++;
    if (cnt !== 256) begin
      n_fail++;
      $display("FAIL init_edges: got %0d want 256", cnt);
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_during_init: got 1 want 0");
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_init: got %b want 1", req_ready);
    end
  endtask

  task automatic test_init_reads();
    logic [7:0] addrs [3];
    addrs[0] = 8'd0;
    addrs[1] = 8'd127;
    addrs[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, addrs[i], 8'h00);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_wr !== 1'b0 || rsp_data !== INIT_VAL) begin
        n_fail++;
        $display("FAIL init_read[%0d]: got vld=%b wr=%b data=%h want 1 0 %h",
                 addrs[i], rsp_valid, rsp_wr, rsp_data, INIT_VAL);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h10;
    req_wdata = 8'hC3;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_wr: got %b want 1", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_write_ack: got vld=%b wr=%b data=%h want 1 1 c3", rsp_valid, rsp_wr, rsp_data);
    end
    req_wr = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_rd: got %b want 1", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b0 || rsp_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_raw_read: got vld=%b wr=%b data=%h want 1 0 c3", rsp_valid, rsp_wr, rsp_data);
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_drain: got vld=%b data=%h want 0 c3", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_backpressure();
    drive_req(1'b0, 8'h20, 8'h00);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h21;
    req_wdata = 8'h77;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ready[%0d]: got %b want 0", i, req_ready);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_wr !== 1'b0 || rsp_data !== INIT_VAL) begin
        n_fail++;
        $display("FAIL hold_rsp[%0d]: got vld=%b wr=%b data=%h want 1 0 5a", i, rsp_valid, rsp_wr, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: got %b want 1", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_data !== 8'h77) begin
      n_fail++;
      $display("FAIL release_accept: got vld=%b wr=%b data=%h want 1 1 77", rsp_valid, rsp_wr, rsp_data);
    end
    req_valid = 1'b0;
    tick();
    drive_req(1'b0, 8'h21, 8'h00);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h77) begin
      n_fail++;
      $display("FAIL release_readback: got vld=%b data=%h want 1 77", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_clr();
    int cnt;
    bit early;
    rsp_ready = 1'b0;
    drive_req(1'b0, 8'h30, 8'h00);
    rsp_ready = 1'b1;
    clr       = 1'b1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h40;
    req_wdata = 8'hEE;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready: got %b want 0", req_ready);
    end
    tick();
    clr       = 1'b0;
    req_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || dbg_state !== INIT) begin
      n_fail++;
      $display("FAIL clr_effect: got vld=%b done=%b state=%0d want 0 0 %0d", rsp_valid, init_done, dbg_state, INIT);
    end
    wait_init(cnt, early);
    n_cmp++;
    if (cnt !== 256 || early !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_reinit: got edges=%0d early=%b want 256 0", cnt, early);
    end
    drive_req(1'b0, 8'h40, 8'h00);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== INIT_VAL) begin
      n_fail++;
      $display("FAIL clr_write_dropped: got vld=%b data=%h want 1 5a", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_rst_mid_sweep();
    int cnt;
    bit early;
    drive_req(1'b1, 8'd200, 8'h22);
    tick();
    pulse_clr();
    for (int i = 0; i < 100; i++) tick();
    n_cmp++;
    if (dbg_state !== INIT || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sweep_state: got state=%0d done=%b want %0d 0", dbg_state, init_done, INIT);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_wr !== 1'b0 || rsp_data !== 8'h00 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got vld=%b wr=%b data=%h done=%b want 0 0 00 0",
               rsp_valid, rsp_wr, rsp_data, init_done);
    end
    wait_init(cnt, early);
    n_cmp++;
    if (cnt !== 256 || early !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_reinit: got edges=%0d early=%b want 256 0", cnt, early);
    end
    drive_req(1'b0, 8'd200, 8'h00);
    n_cmp++;
    if (rsp_data !== INIT_VAL) begin
      n_fail++;
      $display("FAIL rst_mid_read200: got %h want 5a", rsp_data);
    end
    tick();
  endtask

`ifdef LUT_ACCESS_CNT_EN
  task automatic test_counters();
    int cnt;
    bit early;
    pulse_clr();
    wait_init(cnt, early);
    n_cmp++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_start: got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
    end
    for (int i = 0; i < 3; i++) drive_req(1'b1, 8'(i + 1), 8'(i + 8'h90));
    for (int i = 0; i < 5; i++) drive_req(1'b0, 8'(i), 8'h00);
    tick();
    n_cmp++;
    if (rd_cnt !== 16'd5 || wr_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL cnt_values: got rd=%0d wr=%0d want 5 3", rd_cnt, wr_cnt);
    end
    pulse_clr();
    n_cmp++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_clr: got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
    end
    wait_init(cnt, early);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    test_reset();
    test_init_reads();
    test_back_to_back();
    test_backpressure();
    test_clr();
    test_rst_mid_sweep();
`ifdef LUT_ACCESS_CNT_EN
    test_counters();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_access_ctrl.md
Name: lut_access_ctrl

Overview:
- Request/response controller that owns the lookup-table storage and services read and write commands from a requester over a valid/ready handshake.
- It is the servicing end of the table's write/read access pair.
- After reset it sweeps the whole table to a known value, then accepts one command per cycle and returns one response per command, in order.
- Sits between a testbench or driver front-end and the lookup storage.

Parameters:
- ASIZE, 8, address width in bits.
- ARANGE, 1<<ASIZE, number of table entries.
- DWIDTH, 8, data word width in bits.
- INIT_VAL, 0, value written to every entry during the init sweep (DWIDTH bits).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous re-init request; restarts the sweep.
- req_valid  in  1  command valid.
- req_ready  out  1  controller can accept a command.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ASIZE  table address.
- req_wdata  in  DWIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  requester accepts the response.
- rsp_wr  out  1  response is a write acknowledge.
- rsp_data  out  DWIDTH  read data, or the echoed write data.
- init_done  out  1  init sweep complete; table usable.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Outputs after reset: req_ready=0, rsp_valid=0, rsp_wr=0, rsp_data=0, init_done=0.
  - Internal state after reset: state=INIT, sweep pointer=0.
- State INIT:
  - Each cycle, write INIT_VAL at the sweep pointer and increment the pointer.
  - On the cycle that writes address ARANGE-1, go to IDLE.
  - init_done=1 and req_ready becomes eligible from the next cycle.
  - With rst released before edge 0, edges 1..ARANGE write addresses 0..ARANGE-1, and init_done=1 after edge ARANGE.
  - req_ready=0 throughout INIT; commands are not accepted.
- State IDLE:
  - req_ready = init_done && (!rsp_valid || rsp_ready). This is combinational from rsp_ready.
  - A command is accepted when req_valid && req_ready at a rising edge.
- Read accept:
  - rsp_data <= mem[req_addr], rsp_wr <= 0, rsp_valid <= 1.
  - Latency is 1 cycle.
- Write accept:
  - mem[req_addr] <= req_wdata, rsp_data <= req_wdata, rsp_wr <= 1, rsp_valid <= 1.
- Response held:
  - While rsp_valid && !rsp_ready, all rsp_* outputs are held stable.
  - No new command is accepted while the response is held.
- Response drained:
  - rsp_valid && rsp_ready with no new accept in the same cycle: rsp_valid <= 0.
  - rsp_data keeps its last value.
- Back-to-back:
  - A response handshake and a new accept in the same cycle are allowed, giving full throughput of 1 command/cycle.
- Read-after-write:
  - A read of the same address accepted in the cycle after a write returns the new data.
  - No stale read is permitted.
- Address range:
  - req_addr is always in range, because ARANGE = 2^ASIZE.
  - There is no wrap logic beyond the natural ASIZE-bit index.
- Sweep pointer:
  - The pointer is ASIZE+1 bits so the terminal count is unambiguous.
- clr in any state:
  - Next state is INIT with pointer 0, init_done=0 and rsp_valid=0.
  - A pending response is discarded.
  - A command presented in the same cycle as clr is not accepted (req_ready is forced 0 while clr=1).
- rst vs clr:
  - rst has priority over clr.
  - rst mid-sweep or mid-response has the same effect as a full reset.
- Undefined states decode to INIT.

Optional Feature:
- Macro: LUT_ACCESS_CNT_EN.
- With the macro defined:
  - Output rd_cnt[15:0] and output wr_cnt[15:0] are added.
  - Each counts accepted reads or accepted writes respectively.
  - Counters saturate at 16'hFFFF.
  - Counters are cleared by rst and by clr.
  - Counters do not count during INIT.
- Without the macro: the ports and counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package lut_pkg:
  - Typedef lut_state_e {INIT, IDLE}.
  - Default constants LUT_ASIZE=8 and LUT_DWIDTH=8.
  - Typedef lut_req_t {wr, addr, wdata}, parameter-width via the package defaults.
- Sub-module lut_mem:
  - ARANGE x DWIDTH array.
  - Single write port with synchronous write.
  - Single read port with combinational read.
  - The controller registers the read result into rsp_data.

Test Plan:
- Release rst at cycle 0 with ASIZE=8 and INIT_VAL=8'h5A:
  - init_done rises after exactly 256 edges.
  - req_ready=0 before that.
  - Reads of addr 0, 127 and 255 return 8'h5A.
- Write addr 8'h10 = 8'hC3, then a read of addr 8'h10 on the next cycle:
  - Write ack with rsp_wr=1 and rsp_data=8'hC3.
  - Next response rsp_wr=0 with rsp_data=8'hC3.
  - One response per cycle with rsp_ready=1.
- rsp_ready=0 for 3 cycles after a read of addr 8'h20 (data 8'h5A):
  - rsp_valid, rsp_data and rsp_wr are held stable.
  - req_ready=0 for those 3 cycles.
  - req_valid held high is accepted only in the cycle rsp_ready returns to 1.
- Assert clr with a pending response and a write presented in the same cycle:
  - rsp_valid=0 next cycle.
  - The write is not performed; a subsequent read of its address after re-init returns INIT_VAL.
  - init_done is low for 256 cycles.
- Assert rst at sweep pointer = 100, then release: the sweep restarts at addr 0 and init_done takes a full 256 cycles.
- With LUT_ACCESS_CNT_EN: 5 reads and 3 writes give rd_cnt=5 and wr_cnt=3; clr returns both to 0.
